decode_scalar_mw: RTL

DECODE_SCALAR_MW -- requirements
Module: decode_scalar_mw

---
 rtl/common_pkg.sv | 67 ++++++
 rtl/decode_out_fifo.sv | 55 +++++
 rtl/decode_scalar_mw.sv | 126 ++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared scalar-instruction types and the combinational format/field decoder.
// Latency: purely combinational helpers, no state.
// Backpressure: not applicable; consumers apply their own flow control.
package common_pkg;

    localparam logic [7:0] LITERAL_CONSTANT = 8'hFF;

    typedef enum logic [2:0] {
        FMT_SOP2 = 3'd0,
        FMT_SOP1 = 3'd1,
        FMT_SOPK = 3'd2,
        FMT_SOPC = 3'd3,
        FMT_SOPP = 3'd4
    } scalar_inst_format_e;

    typedef struct packed {
        scalar_inst_format_e fmt;
        logic [7:0]          op;
        logic [6:0]          dst;
        logic [7:0]          src0;
        logic [7:0]          src1;
        logic [15:0]         imm16;
        logic [31:0]         literal;
    } scalar_inst_t;

    function automatic logic is_scalar(input logic [31:0] w);
        return w[31:30] == 2'b10;
    endfunction

    // Format precedence: the three reserved 7D-7F encodings beat the SOPK prefix.
    function automatic scalar_inst_t decode_scalar(input logic [31:0] w);
        scalar_inst_t d;
        d.fmt     = FMT_SOP2;
        d.op      = {1'b0, w[29:23]};
        d.dst     = w[22:16];
        d.src0    = w[7:0];
        d.src1    = w[15:8];
        d.imm16   = w[15:0];
        d.literal = '0;
        if (w[29:23] == 7'h7F) begin
            d.fmt = FMT_SOPP;
            d.op  = {1'b0, w[22:16]};
        end else if (w[29:23] == 7'h7E) begin
            d.fmt = FMT_SOPC;
            d.op  = {1'b0, w[22:16]};
        end else if (w[29:23] == 7'h7D) begin
            d.fmt = FMT_SOP1;
            d.op  = w[15:8];
        end else if (w[29:28] == 2'b11) begin
            d.fmt = FMT_SOPK;
            d.op  = {3'b000, w[27:23]};
        end
        return d;
    endfunction

    function automatic logic needs_literal(input scalar_inst_t d);
        logic lit;
        lit = 1'b0;
        case (d.fmt)
            FMT_SOP2, FMT_SOPC: lit = (d.src0 == LITERAL_CONSTANT) || (d.src1 == LITERAL_CONSTANT);
            FMT_SOP1:           lit = (d.src0 == LITERAL_CONSTANT);
            default:            lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/decode_out_fifo.sv
// Generic synchronous FIFO holding decoded entries in push order.
// Latency: a push is visible at pop_vld the cycle after the push edge.
// Backpressure: push_rdy is registered from the next-cycle count, so it never depends on pop_rdy combinationally.
module decode_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic             push;
    logic             pop;

    assign push      = push_vld && push_rdy;
    assign pop       = pop_vld && pop_rdy;
    assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign pop_vld   = (count != '0);
    assign pop_dat   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            push_rdy <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_nxt;
            push_rdy <= (count_nxt != DEPTH[PTR_W:0]);
        end
    end

endmodule

// File: rtl/decode_scalar_mw.sv
// Multi-wave scalar instruction decoder: per-wave literal assembly feeding one shared output queue.
// Latency: one cycle from accept to out_valid when the queue is empty.
// Backpressure: in_ready is a registered not-full; the queue holds its head while out_ready is low.
module decode_scalar_mw
    import common_pkg::*;
#(
    parameter  int NUM_WAVES = 4,
    parameter  int OUT_DEPTH = 4,
    localparam int WID_W     = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [WID_W-1:0] in_wave,
    input  logic             flush,
    input  logic [WID_W-1:0] flush_wave,
    output logic             out_valid,
    input  logic             out_ready,
    output scalar_inst_t     out_inst,
    output logic [WID_W-1:0] out_wave,
    output logic             drop_pulse
);
    typedef enum logic {
        S_REST     = 1'b0,
        S_WAIT_LIT = 1'b1
    } wave_state_e;

    localparam int          ENTRY_W     = $bits(scalar_inst_t) + WID_W;
    localparam logic [WID_W:0] NUM_WAVES_L = NUM_WAVES[WID_W:0];

    wave_state_e  state_q   [NUM_WAVES];
    wave_state_e  state_nxt [NUM_WAVES];
    scalar_inst_t hold_q    [NUM_WAVES];
    scalar_inst_t hold_nxt  [NUM_WAVES];

    scalar_inst_t dec;
    logic         accept;
    logic         wave_ok;
    logic         flush_hit;
    logic         push;
    scalar_inst_t push_inst;
    logic         drop_nxt;
    logic [ENTRY_W-1:0] fifo_dat;

    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_q;
        push      = 1'b0;
        push_inst = '0;
        drop_nxt  = 1'b0;
        dec       = decode_scalar(in_inst);
        accept    = in_valid && in_ready;
        wave_ok   = ({1'b0, in_wave} < NUM_WAVES_L);
        flush_hit = flush && (flush_wave == in_wave);

        if (accept && !wave_ok) begin
            drop_nxt = 1'b1;
        end

        // A flush on the same wave swallows the word silently.
        for (int w = 0; w < NUM_WAVES; w++) begin
            if (accept && wave_ok && !flush_hit && (in_wave == WID_W'(w))) begin
                case (state_q[w])
                    S_REST: begin
                        if (!is_scalar(in_inst)) begin
                            drop_nxt = 1'b1;
                        end else if (needs_literal(dec)) begin
                            hold_nxt[w]  = dec;
                            state_nxt[w] = S_WAIT_LIT;
                        end else begin
                            push      = 1'b1;
                            push_inst = dec;
                        end
                    end
                    S_WAIT_LIT: begin
                        push              = 1'b1;
                        push_inst         = hold_q[w];
                        push_inst.literal = in_inst;
                        hold_nxt[w]       = '0;
                        state_nxt[w]      = S_REST;
                    end
                    default: state_nxt[w] = S_REST;
                endcase
            end
            if (flush && (flush_wave == WID_W'(w))) begin
                state_nxt[w] = S_REST;
                hold_nxt[w]  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WAVES; w++) begin
                state_q[w] <= S_REST;
                hold_q[w]  <= '0;
            end
            drop_pulse <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WAVES; w++) begin
                state_q[w] <= state_nxt[w];
                hold_q[w]  <= hold_nxt[w];
            end
            drop_pulse <= drop_nxt;
        end
    end

    decode_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_out_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push),
        .push_dat ({in_wave, push_inst}),
        .push_rdy (in_ready),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (fifo_dat)
    );

    assign {out_wave, out_inst} = fifo_dat;

endmodule
